// File: rtl/sm83_alu_pkg.sv
// sm83_alu_pkg: shared types and constants for the nibble-serial SM83 ALU.
//   alu_op_t     - 4-bit ALU operation code
//   seq_state_t  - sequencer states IDLE -> LO -> HI -> DONE
//   DAA_ADJ_LO/HI - decimal-adjust correction constants
package sm83_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC,
        OP_AND, OP_XOR, OP_OR,  OP_CP,
        OP_RLC, OP_RRC, OP_RL,  OP_RR,
        OP_SLA, OP_SRA, OP_SRL, OP_DAA
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE, LO, HI, DONE
    } seq_state_t;

    localparam logic [5:0] DAA_ADJ_LO = 6'h06;
    localparam logic [7:0] DAA_ADJ_HI = 8'h60;

    function automatic logic is_sub_op(input alu_op_t op);
        return op inside {OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic is_arith_op(input alu_op_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic is_shift_op(input alu_op_t op);
        return op inside {OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL};
    endfunction

endpackage

// File: rtl/sm83_alu_nibble.sv
// sm83_alu_nibble: combinational 4-bit ALU slice shared by the LO and HI passes.
//   op   in  alu_op_t  operation (DAA is mapped to ADD/SUB by the caller)
//   x    in  4         first operand nibble
//   y    in  4         second operand nibble
//   cin  in  1         carry into bit 0 (raw carry, i.e. !borrow for subtracts)
//   r    out 4         result nibble
//   cout out 1         raw carry out of bit 3 of the nibble
module sm83_alu_nibble
    import sm83_alu_pkg::*;
(
    input  alu_op_t    op,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] r,
    output logic       cout
);

    logic [4:0] sum;

    always_comb begin
        sum  = '0;
        r    = x;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
                r    = sum[3:0];
                cout = sum[4];
            end
            // Subtract as A + ~B + cin; callers invert cout to get the borrow.
            OP_SUB, OP_SBC, OP_CP: begin
                sum  = {1'b0, x} + {1'b0, ~y} + {4'b0000, cin};
                r    = sum[3:0];
                cout = sum[4];
            end
            OP_AND:  r = x & y;
            OP_XOR:  r = x ^ y;
            OP_OR:   r = x | y;
            default: r = x;
        endcase
    end

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// sm83_alu_nibble_seq: runs one 8-bit SM83 ALU op as two 4-bit passes and
// hands the raw flag inputs to the downstream flags block.
//   clk, reset       clock; synchronous active-high reset
//   start            accept a new op (IDLE only)
//   op, a, b         operation and operands
//   carry_flag, half_carry_flag, neg_flag   current C/H/N flags
//   busy             high in LO, HI and DONE
//   done             one-cycle strobe, outputs valid
//   result           result byte
//   zero_out, hc_out, carry_out, shift_out, daa_carry_out, sign_out   raw flags
module sm83_alu_nibble_seq
    import sm83_alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_flag,
    input  logic       half_carry_flag,
    input  logic       neg_flag,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       zero_out,
    output logic       hc_out,
    output logic       carry_out,
    output logic       shift_out,
    output logic       daa_carry_out,
    output logic       sign_out
);

    seq_state_t state, state_next;

    alu_op_t    op_q;
    logic [7:0] a_q, b_q;
    logic       c_q, h_q, n_q;
    logic [3:0] lo_q;
    logic       c4_q;

    logic [7:0] shift_byte;
    logic       shift_bit;
    logic [7:0] daa_adj;
    logic       daa_c;
    logic [7:0] opnd_x, opnd_y;
    alu_op_t    core_op;
    logic       cin_first;
    logic [3:0] core_x, core_y, core_r;
    logic       core_cin, core_cout;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LO;
            LO:      state_next = HI;
            HI:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // ---------------- Shift pre-processing (whole byte) ----------------
    always_comb begin
        shift_byte = a_q;
        shift_bit  = 1'b0;
        case (op_q)
            OP_RLC: begin shift_byte = {a_q[6:0], a_q[7]}; shift_bit = a_q[7]; end
            OP_RRC: begin shift_byte = {a_q[0], a_q[7:1]}; shift_bit = a_q[0]; end
            OP_RL:  begin shift_byte = {a_q[6:0], c_q};    shift_bit = a_q[7]; end
            OP_RR:  begin shift_byte = {c_q, a_q[7:1]};    shift_bit = a_q[0]; end
            OP_SLA: begin shift_byte = {a_q[6:0], 1'b0};   shift_bit = a_q[7]; end
            OP_SRA: begin shift_byte = {a_q[7], a_q[7:1]}; shift_bit = a_q[0]; end
            OP_SRL: begin shift_byte = {1'b0, a_q[7:1]};   shift_bit = a_q[0]; end
            default: ;
        endcase
    end

    // ---------------- DAA correction ----------------
    // DAA reuses the nibble adder: the correction byte becomes operand B and
    // the op is issued as ADD (N=0) or SUB (N=1); its carry is reported only
    // through daa_carry_out.
    always_comb begin
        daa_adj = '0;
        if (h_q || (!n_q && (a_q[3:0] > 4'd9)))
            daa_adj = daa_adj | {2'b00, DAA_ADJ_LO};
        if (c_q || (!n_q && (a_q > 8'h99)))
            daa_adj = daa_adj | DAA_ADJ_HI;
        daa_c = c_q | (!n_q && (a_q > 8'h99));
    end

    // ---------------- Operand / carry selection ----------------
    always_comb begin
        opnd_x    = is_shift_op(op_q) ? shift_byte : a_q;
        opnd_y    = (op_q == OP_DAA) ? daa_adj : b_q;
        core_op   = op_q;
        if (op_q == OP_DAA)
            core_op = n_q ? OP_SUB : OP_ADD;
        case (op_q)
            OP_ADC:        cin_first = c_q;
            OP_SBC:        cin_first = !c_q;
            OP_SUB, OP_CP: cin_first = 1'b1;
            OP_DAA:        cin_first = n_q;
            default:       cin_first = 1'b0;
        endcase
        core_x   = (state == HI) ? opnd_x[7:4] : opnd_x[3:0];
        core_y   = (state == HI) ? opnd_y[7:4] : opnd_y[3:0];
        core_cin = (state == HI) ? c4_q : cin_first;
    end

    sm83_alu_nibble u_nibble (
        .op   (core_op),
        .x    (core_x),
        .y    (core_y),
        .cin  (core_cin),
        .r    (core_r),
        .cout (core_cout)
    );

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= OP_ADD;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= 1'b0;
            h_q           <= 1'b0;
            n_q           <= 1'b0;
            lo_q          <= '0;
            c4_q          <= 1'b0;
            result        <= '0;
            zero_out      <= 1'b0;
            hc_out        <= 1'b0;
            carry_out     <= 1'b0;
            shift_out     <= 1'b0;
            daa_carry_out <= 1'b0;
            sign_out      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    c_q  <= carry_flag;
                    h_q  <= half_carry_flag;
                    n_q  <= neg_flag;
                end
                LO: begin
                    lo_q <= core_r;
                    c4_q <= core_cout;
                end
                HI: begin
                    result        <= {core_r, lo_q};
                    zero_out      <= ({core_r, lo_q} == 8'h00);
                    sign_out      <= core_r[3];
                    hc_out        <= is_arith_op(op_q) ? (is_sub_op(op_q) ? !c4_q : c4_q) : 1'b0;
                    carry_out     <= is_arith_op(op_q) ? (is_sub_op(op_q) ? !core_cout : core_cout)
                                   : (is_shift_op(op_q) ? shift_bit : 1'b0);
                    shift_out     <= is_shift_op(op_q) ? shift_bit : 1'b0;
                    daa_carry_out <= (op_q == OP_DAA) ? daa_c : 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Assertions ----------------
    a_state_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(state));
    a_lo_to_hi:    assert property (@(posedge clk) disable iff (reset) state == LO |=> state == HI);
    a_hi_to_done:  assert property (@(posedge clk) disable iff (reset) state == HI |=> state == DONE);
    a_done_idle:   assert property (@(posedge clk) disable iff (reset) state == DONE |=> state == IDLE);
    a_done_pulse:  assert property (@(posedge clk) disable iff (reset) done |=> !done);

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
// tb_sm83_alu_nibble_seq: self-checking bench for sm83_alu_nibble_seq with
// directed cases and random ops compared against an arithmetic reference model.
module tb_sm83_alu_nibble_seq;
    import sm83_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    alu_op_t    op;
    logic [7:0] a, b;
    logic       carry_flag, half_carry_flag, neg_flag;
    logic       busy, done;
    logic [7:0] result;
    logic       zero_out, hc_out, carry_out, shift_out, daa_carry_out, sign_out;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0] r;
        logic       z, h, c, so, dc, s;
    } exp_t;

    sm83_alu_nibble_seq dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .a               (a),
        .b               (b),
        .carry_flag      (carry_flag),
        .half_carry_flag (half_carry_flag),
        .neg_flag        (neg_flag),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .zero_out        (zero_out),
        .hc_out          (hc_out),
        .carry_out       (carry_out),
        .shift_out       (shift_out),
        .daa_carry_out   (daa_carry_out),
        .sign_out        (sign_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model straight from the instruction-set rules.
    function automatic exp_t model(input alu_op_t o, input int av, input int bv,
                                   input int cv, input int hv, input int nv);
        exp_t e;
        int   s, hs, r, cin, adj, so;
        e = '0; r = 0; so = 0;
        case (o)
            OP_ADD, OP_ADC: begin
                cin = (o == OP_ADC) ? cv : 0;
                s = av + bv + cin; hs = (av % 16) + (bv % 16) + cin;
                r = s % 256; e.h = (hs > 15); e.c = (s > 255);
            end
            OP_SUB, OP_SBC, OP_CP: begin
                cin = (o == OP_SBC) ? cv : 0;
                s = av - bv - cin; hs = (av % 16) - (bv % 16) - cin;
                r = (s + 256) % 256; e.h = (hs < 0); e.c = (s < 0);
            end
            OP_AND: r = av & bv;
            OP_XOR: r = av ^ bv;
            OP_OR:  r = av | bv;
            OP_RLC: begin so = av / 128; r = (av * 2) % 256 + so; end
            OP_RRC: begin so = av % 2;   r = av / 2 + so * 128; end
            OP_RL:  begin so = av / 128; r = (av * 2) % 256 + cv; end
            OP_RR:  begin so = av % 2;   r = av / 2 + cv * 128; end
            OP_SLA: begin so = av / 128; r = (av * 2) % 256; end
            OP_SRA: begin so = av % 2;   r = av / 2 + (av / 128) * 128; end
            OP_SRL: begin so = av % 2;   r = av / 2; end
            OP_DAA: begin
                adj = 0;
                if (nv == 0) begin
                    if (hv != 0 || (av % 16) > 9) adj += 6;
                    if (cv != 0 || av > 153) begin adj += 96; e.dc = 1'b1; end
                    r = (av + adj) % 256;
                end else begin
                    if (hv != 0) adj += 6;
                    if (cv != 0) adj += 96;
                    r = (av - adj + 256) % 256;
                    e.dc = (cv != 0);
                end
            end
            default: r = 0;
        endcase
        if (o inside {OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL}) begin
            e.so = (so != 0);
            e.c  = (so != 0);
        end
        e.r = 8'(r);
        e.z = (r == 0);
        e.s = (r >= 128);
        return e;
    endfunction

    task automatic check_outputs(input string pfx, input exp_t e);
        check({pfx, " result"}, 32'(result),        32'(e.r));
        check({pfx, " zero"},   32'(zero_out),      32'(e.z));
        check({pfx, " hc"},     32'(hc_out),        32'(e.h));
        check({pfx, " carry"},  32'(carry_out),     32'(e.c));
        check({pfx, " shift"},  32'(shift_out),     32'(e.so));
        check({pfx, " daa_c"},  32'(daa_carry_out), 32'(e.dc));
        check({pfx, " sign"},   32'(sign_out),      32'(e.s));
    endtask

    // Issue one op from IDLE, scramble inputs after acceptance, expect done at N+3.
    task automatic do_op(input alu_op_t o, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic hv, input logic nv);
        exp_t  e;
        int    cycles;
        logic  seen;
        string pfx;
        e   = model(o, int'(av), int'(bv), int'(cv), int'(hv), int'(nv));
        pfx = $sformatf("%s a=%02h b=%02h c=%0d h=%0d n=%0d", o.name(), av, bv, cv, hv, nv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        carry_flag = cv; half_carry_flag = hv; neg_flag = nv;
        @(negedge clk);
        start = 1'b0;
        op = alu_op_t'(4'($urandom)); a = 8'($urandom); b = 8'($urandom);
        carry_flag = 1'($urandom); half_carry_flag = 1'($urandom); neg_flag = 1'($urandom);
        cycles = 1; seen = 1'b0;
        while (!seen && cycles < 8) begin
            if (done) seen = 1'b1;
            else begin @(negedge clk); cycles++; end
        end
        check({pfx, " done_seen"}, 32'(seen), 32'd1);
        check({pfx, " latency"},   32'(cycles), 32'd3);
        check({pfx, " busy"},      32'(busy), 32'd1);
        check_outputs(pfx, e);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   dcount, first_k, second_k;
        logic [7:0] r_seen;

        reset = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
        carry_flag = 1'b0; half_carry_flag = 1'b0; neg_flag = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check_outputs("reset", '0);
        reset = 1'b0;

        // Directed cases
        do_op(OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);
        do_op(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(OP_SBC, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
        do_op(OP_CP,  8'h20, 8'h20, 1'b0, 1'b0, 1'b0);
        do_op(OP_RL,  8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(OP_SRA, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(OP_DAA, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1);
        do_op(OP_ADC, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op(OP_RR,  8'h01, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random ops
        for (int i = 0; i < 300; i++)
            do_op(alu_op_t'(4'($urandom_range(0, 15))), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));

        // start held through LO/HI/DONE with different inputs: one done only
        e = model(OP_ADD, 'h12, 'h34, 0, 0, 0);
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h12; b = 8'h34;
        carry_flag = 1'b0; half_carry_flag = 1'b0; neg_flag = 1'b0;
        dcount = 0; r_seen = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin op = OP_XOR; a = 8'hA5; b = 8'h5A; end
            if (done) begin dcount++; r_seen = result; end
            if (k == 4) start = 1'b0;
        end
        check("repulse done_count", 32'(dcount), 32'd1);
        check("repulse result",     32'(r_seen), 32'(e.r));

        // start held continuously: dones 4 cycles apart
        @(negedge clk);
        start = 1'b1; op = OP_OR; a = 8'h0F; b = 8'hF0;
        first_k = -1; second_k = -1;
        for (int k = 1; k <= 20 && second_k < 0; k++) begin
            @(negedge clk);
            if (done) begin
                if (first_k < 0) first_k = k;
                else begin second_k = k; start = 1'b0; end
            end
        end
        start = 1'b0;
        check("b2b first_done", 32'(first_k), 32'd3);
        check("b2b spacing",    32'(second_k - first_k), 32'd4);
        check("b2b result",     32'(result), 32'hFF);
        repeat (4) @(negedge clk);

        // reset in HI: nonzero outputs first, then abort mid-op
        do_op(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_hi busy", 32'(busy), 32'd0);
        check("rst_hi done", 32'(done), 32'd0);
        check_outputs("rst_hi", '0);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("rst_hi no_done", 32'(dcount), 32'd0);
        do_op(OP_ADD, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
